mdu_iter: RTL

Iterative RV64M multiply/divide unit in the EX stage, driven by the same `a`/`b` operands the ALU receives from the operand-select mux. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W variants. It runs over multiple cycles with a start/busy/done handshake. The hazard unit stalls the pipeline while `busy` is high.

---
 rtl/mdu_iter_if.sv | 32 +++
 rtl/mdu_iter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: start/busy/done handshake and operand/result bus of the
// iterative multiply/divide unit.
//   start  : request, accepted by the unit only while idle and not flushed
//   op     : {word, funct3}
//   a, b   : rs1/rs2 operands, sampled on the accept edge
//   flush  : kill any in-flight operation
//   busy   : operation in progress (pipeline stall)
//   done   : one-cycle pulse, result valid
//   result : result register, held until the next done
// master modport = EX-stage driver, slave modport = mdu_iter.
interface mdu_iter_if #(
  parameter int unsigned XLEN = 64
);
  logic            start;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit (radix-2 shift-add multiply,
// restoring divide, one bit per cycle).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mdu_iter_if.slave (start/op/a/b/flush in, busy/done/result out)
// Build option: define MDU_WORD_OPS_EN to support the W variants (op[3]);
// otherwise op[3] is ignored and every op runs as its 64-bit form.
// Latency from accept edge to done: 66 edges (34 for W ops), 2 on the
// divide-by-zero / signed-overflow fast-path.
module mdu_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q;
  logic [5:0]      cnt_q;
  logic            first_q, word_q, fast_q, sa_q, sb_q, busy_q, done_q;
  logic [2:0]      fn_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q, fast_res_q, result_q;

  // ---------------- accept-time decode ----------------
  logic            word_d, sa_d, sb_d, fast_d, signed_a, signed_b;
  logic [2:0]      fn_d;
  logic [XLEN-1:0] a_v, b_v, amag_d, bmag_d, min_v, fast_res_d;

`ifndef MDU_WORD_OPS_EN
  logic unused_op3;
  assign unused_op3 = bus.op[3];
`endif

  always_comb begin
    word_d = 1'b0;
`ifdef MDU_WORD_OPS_EN
    word_d = bus.op[3];
`endif
    fn_d = bus.op[2:0];
    // W forms of MULH/MULHSU/MULHU do not exist; they run as MULW
    if (word_d && !fn_d[2]) fn_d = 3'b000;
    signed_a = (fn_d == 3'b001) || (fn_d == 3'b010) || (fn_d == 3'b100) || (fn_d == 3'b110);
    signed_b = (fn_d == 3'b001) || (fn_d == 3'b100) || (fn_d == 3'b110);
    a_v   = bus.a;
    b_v   = bus.b;
    min_v = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MDU_WORD_OPS_EN
    if (word_d) begin
      a_v   = {{32{bus.a[31]}}, bus.a[31:0]};
      b_v   = {{32{bus.b[31]}}, bus.b[31:0]};
      min_v = {{33{1'b1}}, 31'b0};
    end
`endif
    sa_d   = signed_a & a_v[XLEN-1];
    sb_d   = signed_b & b_v[XLEN-1];
    amag_d = sa_d ? -a_v : a_v;
    bmag_d = sb_d ? -b_v : b_v;
`ifdef MDU_WORD_OPS_EN
    // 32-bit magnitude (|-2^31| still fits); unsigned W ops zero-extend
    if (word_d) begin
      amag_d = {32'b0, amag_d[31:0]};
      bmag_d = {32'b0, bmag_d[31:0]};
    end
`endif
    fast_d     = 1'b0;
    fast_res_d = '0;
    if (fn_d[2]) begin
      if (b_v == '0) begin
        fast_d     = 1'b1;
        fast_res_d = fn_d[1] ? a_v : '1;
      end else if (!fn_d[0] && (a_v == min_v) && (b_v == '1)) begin
        fast_d     = 1'b1;
        fast_res_d = fn_d[1] ? '0 : a_v;
      end
    end
  end

  // ---------------- one iteration ----------------
  logic [XLEN-1:0] addend, hi_d, lo_d;
  logic [XLEN:0]   mul_sum, rem_sh, diff;
  logic            last;

  always_comb begin
    addend  = lo_q[0] ? m_q : '0;
    mul_sum = {1'b0, hi_q} + {1'b0, addend};
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, m_q};
    if (fn_q[2]) begin
      if (!diff[XLEN]) begin
        hi_d = diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    last = (cnt_q == (word_q ? 6'd31 : 6'd63));
  end

  // ---------------- sign fix / select ----------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = {hi_q, lo_q};
    if (sa_q ^ sb_q) prod = -prod;
    quo = lo_q;
`ifdef MDU_WORD_OPS_EN
    if (word_q) quo = {32'b0, lo_q[31:0]};
`endif
    if (sa_q ^ sb_q) quo = -quo;
    rem = sa_q ? -hi_q : hi_q;
    if (fast_q)                  fix_res = fast_res_q;
    else if (fn_q[2])            fix_res = fn_q[1] ? rem : quo;
    else if (fn_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
    else                         fix_res = prod[2*XLEN-1:XLEN];
`ifdef MDU_WORD_OPS_EN
    // 32 shifts leave a W product in the upper half of lo
    if (word_q && !fast_q) begin
      if (!fn_q[2]) fix_res = {{32{lo_q[63]}}, lo_q[63:32]};
      else          fix_res = {{32{fix_res[31]}}, fix_res[31:0]};
    end
`endif
  end

  // ---------------- control ----------------
  // The first CALC cycle after accept only raises busy (or branches to FIX on
  // the fast-path); the N iterations follow, giving accept->done of N+2 edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      word_q     <= 1'b0;
      fast_q     <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      fn_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      fast_res_q <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            state_q    <= CALC;
            first_q    <= 1'b1;
            cnt_q      <= '0;
            word_q     <= word_d;
            fn_q       <= fn_d;
            fast_q     <= fast_d;
            fast_res_q <= fast_res_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            hi_q       <= '0;
            if (fn_d[2]) begin
              lo_q <= word_d ? {amag_d[31:0], 32'b0} : amag_d;
              m_q  <= bmag_d;
            end else begin
              lo_q <= bmag_d;
              m_q  <= amag_d;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (first_q) begin
            first_q <= 1'b0;
            busy_q  <= 1'b1;
            if (fast_q) state_q <= FIX;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 6'd1;
            if (last) state_q <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
